// File: rtl/nanorv32_ahbl_ram_if.sv
// AHB-Lite bus bundle between the nanorv32 manager side and the RAM responder.
//   master : drives hsel/haddr/htrans/hwrite/hsize/hwdata and the bus-wide hready
//   slave  : drives hrdata/hreadyout/hresp back to the manager
interface nanorv32_ahbl_ram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/nanorv32_ahbl_ram.sv
// AHB-Lite responder RAM (tightly coupled memory for the simpleahb chip).
// Serves byte/half/word reads and writes with WAIT_STATES extra data-phase
// cycles per OKAY transfer; out-of-window, misaligned or oversize accesses get
// a two-cycle ERROR response and never touch the RAM.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (RAM contents are kept)
//   bus    : AHB-Lite slave modport (address/control/wdata in, rdata/readyout/resp out)
module nanorv32_ahbl_ram #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_BITS = 16,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nanorv32_ahbl_ram_if.slave       bus
);
  localparam int unsigned IW    = MEM_ADDR_BITS - 2;
  localparam int unsigned DEPTH = 2 ** IW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  logic [31:0]   ram [DEPTH];

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dphase_q, dphase_d;   // an OKAY transfer is in its data phase
  logic          write_q, write_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic [31:0]   off;
  logic [IW-1:0] acc_idx;
  logic [IW-1:0] rd_idx;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic          slot_free;
  logic          accept;
  logic          commit;
  logic [31:0]   rd_data;
  logic          unused_ok;

  // Address decode for the transfer currently in its address phase.
  always_comb begin
    off     = bus.haddr - BASE_ADDR;
    acc_idx = off[MEM_ADDR_BITS-1:2];
    unique case (bus.hsize)
      3'd0:    acc_be = 4'b0001 << bus.haddr[1:0];
      3'd1:    acc_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: acc_be = 4'b1111;
    endcase
    // Subtraction wraps addresses below BASE_ADDR to large offsets, so one
    // upper-bits test covers both ends of the window.
    acc_err = (bus.hsize > 3'd2)
           || ((off >> MEM_ADDR_BITS) != '0)
           || ((bus.hsize == 3'd1) && bus.haddr[0])
           || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  end

  assign slot_free = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept    = slot_free && bus.hsel && bus.hready && bus.htrans[1];
  // Completing cycle of an OKAY write: hwdata is valid now, RAM updates at the edge.
  assign commit    = dphase_q && write_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // RAM read with bypass of a write committing at the same edge, so a read
  // pipelined directly behind a write to the same word sees the merged word.
  always_comb begin
    rd_idx  = (state_q == ST_WAIT) ? idx_q : acc_idx;
    rd_data = ram[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be_q[l]) rd_data[8*l +: 8] = bus.hwdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = dphase_q;
    write_d  = write_q;
    idx_d    = idx_q;
    be_d     = be_q;
    hrdata_d = '0;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!write_q) hrdata_d = rd_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DONE and ERR2 all have hreadyout high and can take a new accept.
        state_d  = ST_IDLE;
        dphase_d = 1'b0;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            dphase_d = 1'b1;
            write_d  = bus.hwrite;
            idx_d    = acc_idx;
            be_d     = acc_be;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end else if (!bus.hwrite) begin
              hrdata_d = rd_data;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Storage is not reset; a reset in the completing cycle drops the write.
  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be_q[l]) ram[idx_q][8*l +: 8] <= bus.hwdata[8*l +: 8];
      end
    end
  end

  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign bus.hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

  // SEQ is handled as NONSEQ; byte offset bits are covered by haddr itself.
  assign unused_ok = &{1'b0, bus.htrans[0], off[1:0]};
endmodule

// File: tb/tb_nanorv32_ahbl_ram.sv
// Self-checking bench for nanorv32_ahbl_ram: three instances (0, 2 and 3 wait
// states, 1 KiB window) share one directed stimulus stream, steered by `sel`.
// A transaction-level model predicts each cycle's hreadyout/hresp/hrdata.
module tb_nanorv32_ahbl_ram;
  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        c_hreadyout, c_hresp;
  logic [31:0] c_hrdata;
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  nanorv32_ahbl_ram_if b0 ();
  nanorv32_ahbl_ram_if b1 ();
  nanorv32_ahbl_ram_if b2 ();

  assign b0.hsel = m_hsel && (sel == 0);
  assign b1.hsel = m_hsel && (sel == 1);
  assign b2.hsel = m_hsel && (sel == 2);
  assign b0.haddr = m_haddr;  assign b1.haddr = m_haddr;  assign b2.haddr = m_haddr;
  assign b0.htrans = m_htrans; assign b1.htrans = m_htrans; assign b2.htrans = m_htrans;
  assign b0.hwrite = m_hwrite; assign b1.hwrite = m_hwrite; assign b2.hwrite = m_hwrite;
  assign b0.hsize = m_hsize;  assign b1.hsize = m_hsize;  assign b2.hsize = m_hsize;
  assign b0.hwdata = m_hwdata; assign b1.hwdata = m_hwdata; assign b2.hwdata = m_hwdata;
  assign b0.hready = b0.hreadyout;
  assign b1.hready = b1.hreadyout;
  assign b2.hready = b2.hreadyout;

  nanorv32_ahbl_ram #(.BASE_ADDR(32'h0), .MEM_ADDR_BITS(10), .WAIT_STATES(0))
    u_ws0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  nanorv32_ahbl_ram #(.BASE_ADDR(32'h0), .MEM_ADDR_BITS(10), .WAIT_STATES(2))
    u_ws2 (.clk(clk), .rst_n(rst_n), .bus(b1));
  nanorv32_ahbl_ram #(.BASE_ADDR(32'h0), .MEM_ADDR_BITS(10), .WAIT_STATES(3))
    u_ws3 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always_comb begin
    case (sel)
      0: begin c_hreadyout = b0.hreadyout; c_hresp = b0.hresp; c_hrdata = b0.hrdata; end
      1: begin c_hreadyout = b1.hreadyout; c_hresp = b1.hresp; c_hrdata = b1.hrdata; end
      default: begin c_hreadyout = b2.hreadyout; c_hresp = b2.hresp; c_hrdata = b2.hrdata; end
    endcase
  end

  // ---------------- behavioural model ----------------
  logic [31:0] mem [3][256];
  logic [33:0] expq [$];          // {hreadyout, hresp, hrdata} per upcoming cycle
  int          ph_left = 0;       // data-phase cycles still owed by the model
  logic        cur_good, cur_write;
  logic [31:0] cur_addr;
  logic [2:0]  cur_size;

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 3;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (a >= 32'd1024) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic mwrite(input int s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w, lo;
    w  = int'(a / 4);
    lo = int'(a % 4);
    for (int l = 0; l < 4; l++) begin
      if (sz == 3'd2 || l == lo || (sz == 3'd1 && l == lo + 1))
        mem[s][w][8*l +: 8] = d[8*l +: 8];
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      ph_left = 0;
      expq.delete();
    end else begin
      if (ph_left > 0) begin
        if (ph_left == 1 && cur_good && cur_write) mwrite(sel, cur_addr, cur_size, m_hwdata);
        ph_left--;
      end
      if (ph_left == 0 && m_hsel && m_htrans[1]) begin
        if (is_err(m_haddr, m_hsize)) begin
          cur_good = 1'b0;
          ph_left  = 2;
          expq.push_back({1'b0, 1'b1, 32'h0});
          expq.push_back({1'b1, 1'b1, 32'h0});
        end else begin
          cur_good  = 1'b1;
          cur_write = m_hwrite;
          cur_addr  = m_haddr;
          cur_size  = m_hsize;
          ph_left   = ws_of(sel) + 1;
          for (int i = 0; i < ws_of(sel); i++) expq.push_back({1'b0, 1'b0, 32'h0});
          expq.push_back({1'b1, 1'b0, m_hwrite ? 32'h0 : mem[sel][m_haddr / 4]});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e, a;
    if (chk_en) begin
      e = (expq.size() > 0) ? expq.pop_front() : {1'b1, 1'b0, 32'h0};
      a = {c_hreadyout, c_hresp, c_hrdata};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t sel=%0d got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                 $time, sel, a[33], a[32], a[31:0], e[33], e[32], e[31:0]);
      end
    end
  end

  // ---------------- driver and literal checks ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Presents an address phase, waits for the bus to be ready (the previous
  // transfer's completing cycle, whose hrdata is returned), then enters the
  // data phase with wd on hwdata.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] pd, output int lows);
    m_hsel = 1'b1; m_haddr = a; m_htrans = 2'b10; m_hwrite = w; m_hsize = sz;
    lows = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (c_hreadyout) begin pd = c_hrdata; break; end
      lows++;
      if (lows > 40) begin
        total++; bad++;
        $display("FAIL xfer_timeout addr=%h got no hready want hready within 40 cycles", a);
        break;
      end
    end
    @(posedge clk); #1;
    m_hwdata = wd; m_hsel = 1'b0; m_htrans = 2'b00;
  endtask

  task automatic finish(output logic [31:0] d, output int lows);
    m_hsel = 1'b0; m_htrans = 2'b00;
    lows = 0;
    d = '0;
    forever begin
      @(negedge clk);
      if (c_hreadyout) begin d = c_hrdata; break; end
      lows++;
      if (lows > 40) begin
        total++; bad++;
        $display("FAIL finish_timeout got no hready want hready within 40 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] want);
    logic [31:0] d; int l;
    xfer(a, 1'b0, 3'd2, 32'h0, d, l);
    finish(d, l);
    chk(nm, d, want);
  endtask

  task automatic err_seq(input string nm, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] d; int l;
    xfer(a, w, sz, wd, d, l);
    @(negedge clk);
    chk({nm, "_ph1"}, {30'h0, c_hreadyout, c_hresp}, 32'h1);
    @(negedge clk);
    chk({nm, "_ph2"}, {30'h0, c_hreadyout, c_hresp}, 32'h3);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d, d2;
    int l, l2;
    logic [31:0] pre [5];
    pre[0] = 32'h00; pre[1] = 32'h04; pre[2] = 32'h08; pre[3] = 32'h0C; pre[4] = 32'h80;

    rst_n = 1'b0; sel = 0;
    m_hsel = 1'b0; m_haddr = '0; m_htrans = 2'b00; m_hwrite = 1'b0; m_hsize = 3'd2; m_hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ws0", {b0.hreadyout, b0.hresp, b0.hrdata[29:0]}, 32'h8000_0000);
    chk("reset_ws0_rdata", b0.hrdata, 32'h0);
    chk("reset_ws2", {b1.hreadyout, b1.hresp, b1.hrdata[29:0]}, 32'h8000_0000);
    chk("reset_ws3", {b2.hreadyout, b2.hresp, b2.hrdata[29:0]}, 32'h8000_0000);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Known contents in every instance, written back to back.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 5; i++) xfer(pre[i], 1'b1, 3'd2, 32'hA500_0000 | (pre[i] >> 2), d, l);
      finish(d, l);
    end

    // Zero wait states: write then pipelined read.
    sel = 0;
    xfer(32'h100, 1'b1, 3'd2, 32'hCAFF_E000, d, l);
    xfer(32'h100, 1'b0, 3'd2, 32'h0, d, l);
    chk("ws0_wr_stall", l, 0);
    finish(d, l);
    chk("ws0_rd_stall", l, 0);
    chk("ws0_rd_data", d, 32'hCAFF_E000);

    // Byte lanes.
    xfer(32'h20, 1'b1, 3'd2, 32'h1122_3344, d, l);
    xfer(32'h22, 1'b1, 3'd0, 32'h00AA_0000, d, l);
    xfer(32'h20, 1'b1, 3'd1, 32'h0000_BEEF, d, l);
    xfer(32'h20, 1'b0, 3'd2, 32'h0, d, l);
    finish(d, l);
    chk("lanes", d, 32'h11AA_BEEF);

    // Read-after-write with no stall.
    xfer(32'h40, 1'b1, 3'd2, 32'h0DEA_D000, d, l);
    xfer(32'h40, 1'b0, 3'd2, 32'h0, d, l);
    chk("raw_accept_stall", l, 0);
    finish(d, l);
    chk("raw_data", d, 32'h0DEA_D000);
    chk("raw_rd_stall", l, 0);

    // Error responses leave RAM untouched.
    err_seq("err_range", 32'h400, 1'b0, 3'd2, 32'h0);
    read_chk("err_range_after", 32'h0, 32'hA500_0000);
    err_seq("err_misalign", 32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF);
    read_chk("err_misalign_after", 32'h0, 32'hA500_0000);
    err_seq("err_size", 32'h8, 1'b1, 3'd3, 32'hFFFF_FFFF);
    read_chk("err_size_after", 32'h8, 32'hA500_0002);
    err_seq("err_half_odd", 32'h5, 1'b1, 3'd1, 32'hFFFF_FFFF);
    read_chk("err_half_after", 32'h4, 32'hA500_0001);

    // Two wait states.
    sel = 1;
    xfer(32'h4, 1'b0, 3'd2, 32'h0, d, l);
    finish(d, l);
    chk("ws2_lows", l, 2);
    chk("ws2_data", d, 32'hA500_0001);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, d, l);
    xfer(32'h8, 1'b0, 3'd2, 32'h0, d, l);
    chk("ws2_b2b_lows1", l, 2);
    chk("ws2_b2b_data1", d, 32'hA500_0001);
    finish(d2, l2);
    chk("ws2_b2b_lows2", l2, 2);
    chk("ws2_b2b_data2", d2, 32'hA500_0002);
    xfer(32'hC, 1'b1, 3'd2, 32'h1234_5678, d, l);
    xfer(32'hC, 1'b0, 3'd2, 32'h0, d, l);
    finish(d, l);
    chk("ws2_raw", d, 32'h1234_5678);

    // Reset in the middle of a three-wait-state write.
    sel = 2;
    xfer(32'h80, 1'b1, 3'd2, 32'hDEAD_BEEF, d, l);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_rdy_resp", {30'h0, c_hreadyout, c_hresp}, 32'h2);
    chk("rst_mid_rdata", c_hrdata, 32'h0);
    @(posedge clk); #1;
    xfer(32'h80, 1'b0, 3'd2, 32'h0, d, l);
    finish(d, l);
    chk("rst_mid_lows", l, 3);
    chk("rst_mid_old", d, 32'hA500_0020);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1);
  end
endmodule
